truth_table_sweep_checker: RTL and testbench

// Synthesizable, parametrised generator/checker for N_CH combinational realisations
// (e.g. DDNF/DKNF) of one IN_W->OUT_W truth table. Sweeps every input vector 0..2^IN_W-1,

---
 rtl/truth_table_sweep_checker.sv | 172 +++++++++++++++++
 tb/tb_truth_table_sweep_checker.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweep_checker.sv
// Sweeps every IN_W-bit input vector through N_CH DUT channels, compares each channel
// against a synchronous expected-value ROM and accumulates error statistics.
module truth_table_sweep_checker #(
  parameter int IN_W   = 9,
  parameter int OUT_W  = 4,
  parameter int N_CH   = 2,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic                  stop_on_err_i,
  output logic [IN_W-1:0]       stim_o,
  input  logic [N_CH*OUT_W-1:0] dut_y_i,
  output logic [IN_W-1:0]       exp_addr_o,
  input  logic [OUT_W-1:0]      exp_data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [CNT_W-1:0]      err_cnt_o,
  output logic [N_CH-1:0]       err_ch_mask_o,
  output logic                  first_fail_vld_o,
  output logic [IN_W-1:0]       first_fail_idx_o
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [SW-1:0]    SETTLE_ONE  = SW'(1);
  localparam logic [IN_W-1:0]  STIM_LAST   = {IN_W{1'b1}};
  localparam logic [IN_W-1:0]  STIM_ONE    = IN_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_CMP   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e           state_q,    state_d;
  logic [IN_W-1:0]  stim_q,     stim_d;
  logic [SW-1:0]    settle_q,   settle_d;
  logic [CNT_W-1:0] err_cnt_q,  err_cnt_d;
  logic [N_CH-1:0]  mask_q,     mask_d;
  logic             ff_vld_q,   ff_vld_d;
  logic [IN_W-1:0]  ff_idx_q,   ff_idx_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;
  logic             pass_q,     pass_d;
  logic [N_CH-1:0]  mism_s;
  logic             any_mism_s;

  // Per-channel mismatch; case inequality so X/Z on a channel counts as a failure in simulation.
  always_comb begin
    mism_s = '0;
    for (int c = 0; c < N_CH; c++) begin
      mism_s[c] = (dut_y_i[c*OUT_W +: OUT_W] !== exp_data_i);
    end
    any_mism_s = |mism_s;
  end

  // Sweep sequencing and result accumulation; abort takes priority over everything else.
  always_comb begin
    state_d   = state_q;
    stim_d    = stim_q;
    settle_d  = settle_q;
    err_cnt_d = err_cnt_q;
    mask_d    = mask_q;
    ff_vld_d  = ff_vld_q;
    ff_idx_d  = ff_idx_q;
    if (abort_i) begin
      state_d  = ST_IDLE;
      settle_d = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state_d   = ST_APPLY;
            stim_d    = '0;
            settle_d  = '0;
            err_cnt_d = '0;
            mask_d    = '0;
            ff_vld_d  = 1'b0;
            ff_idx_d  = '0;
          end else begin
            state_d = state_q;
          end
        end
        ST_APPLY: begin
          if (settle_q == SETTLE_LAST) begin
            state_d  = ST_CMP;
            settle_d = '0;
          end else begin
            settle_d = settle_q + SETTLE_ONE;
          end
        end
        ST_CMP: begin
          if (any_mism_s) begin
            if (err_cnt_q != CNT_MAX) begin
              err_cnt_d = err_cnt_q + CNT_ONE;
            end else begin
              err_cnt_d = err_cnt_q;
            end
            mask_d = mask_q | mism_s;
            if (!ff_vld_q) begin
              ff_vld_d = 1'b1;
              ff_idx_d = stim_q;
            end else begin
              ff_vld_d = ff_vld_q;
            end
          end else begin
            mask_d = mask_q;
          end
          // The last vector is compared before finishing; stim never wraps back to zero.
          if ((stim_q == STIM_LAST) || (stop_on_err_i && any_mism_s)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_APPLY;
            stim_d  = stim_q + STIM_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    busy_d = (state_d == ST_APPLY) || (state_d == ST_CMP);
    done_d = (state_d == ST_DONE);
    pass_d = done_d && (err_cnt_d == '0);
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      stim_q    <= '0;
      settle_q  <= '0;
      err_cnt_q <= '0;
      mask_q    <= '0;
      ff_vld_q  <= 1'b0;
      ff_idx_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      stim_q    <= stim_d;
      settle_q  <= settle_d;
      err_cnt_q <= err_cnt_d;
      mask_q    <= mask_d;
      ff_vld_q  <= ff_vld_d;
      ff_idx_q  <= ff_idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  assign stim_o           = stim_q;
  assign exp_addr_o       = stim_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign pass_o           = pass_q;
  assign err_cnt_o        = err_cnt_q;
  assign err_ch_mask_o    = mask_q;
  assign first_fail_vld_o = ff_vld_q;
  assign first_fail_idx_o = ff_idx_q;

endmodule

// File: tb/tb_truth_table_sweep_checker.sv
// Directed bench for truth_table_sweep_checker: a modelled two-channel DUT with injectable
// per-vector faults, a 1-cycle-latency ROM, and a CNT_W=2 twin for counter saturation.
module tb_truth_table_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start, abort, stop_on_err;
  logic [511:0] flt0, flt1;
  int           n_tests = 0;
  int           n_fail  = 0;

  logic [8:0] stim_a, addr_a, idx_a, stim_b, addr_b, idx_b;
  logic [7:0] dut_y_a, dut_y_b;
  logic [3:0] rom_a, rom_b;
  logic [9:0] err_a;
  logic [1:0] err_b, mask_a, mask_b;
  logic       busy_a, done_a, pass_a, vld_a, busy_b, done_b, pass_b, vld_b;

  function automatic logic [3:0] ref_f(input logic [8:0] v);
    return v[3:0] ^ v[7:4] ^ {3'b000, v[8]};
  endfunction

  always_comb begin
    dut_y_a = {ref_f(stim_a) ^ {4{flt1[stim_a]}}, ref_f(stim_a) ^ {4{flt0[stim_a]}}};
    dut_y_b = {ref_f(stim_b) ^ {4{flt1[stim_b]}}, ref_f(stim_b) ^ {4{flt0[stim_b]}}};
  end

  always_ff @(posedge clk) begin
    rom_a <= ref_f(addr_a);
    rom_b <= ref_f(addr_b);
  end

  truth_table_sweep_checker #(.IN_W(9), .OUT_W(4), .N_CH(2), .SETTLE(2), .CNT_W(10)) dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort), .stop_on_err_i(stop_on_err),
    .stim_o(stim_a), .dut_y_i(dut_y_a), .exp_addr_o(addr_a), .exp_data_i(rom_a),
    .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a), .err_cnt_o(err_a),
    .err_ch_mask_o(mask_a), .first_fail_vld_o(vld_a), .first_fail_idx_o(idx_a)
  );

  truth_table_sweep_checker #(.IN_W(9), .OUT_W(4), .N_CH(2), .SETTLE(2), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort), .stop_on_err_i(stop_on_err),
    .stim_o(stim_b), .dut_y_i(dut_y_b), .exp_addr_o(addr_b), .exp_data_i(rom_b),
    .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b), .err_cnt_o(err_b),
    .err_ch_mask_o(mask_b), .first_fail_vld_o(vld_b), .first_fail_idx_o(idx_b)
  );

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Returns cyc = negedges seen since the start-sampling edge; cyc-1 is start->done latency.
  task automatic wait_done(input int budget, output int cyc);
    cyc = 1;
    while (!done_a && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    n_tests++;
    if (done_a !== 1'b1) begin
      n_fail++;
      $display("FAIL sweep_timeout: done=%b after %0d cycles, required 1", done_a, cyc);
    end
  endtask

  task automatic run_sweep(output int cyc);
    pulse_start();
    wait_done(2000, cyc);
  endtask

  task automatic wait_stim(input logic [8:0] target);
    int n = 0;
    while (stim_a !== target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (stim_a !== target) begin
      n_fail++;
      $display("FAIL wait_stim: stim=%h, required %h", stim_a, target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; stop_on_err = 1'b0;
    flt0 = '0; flt1 = '0;
    #12;
    n_tests++;
    if ({stim_a, addr_a, busy_a, done_a, pass_a, err_a, mask_a, vld_a, idx_a} !== 46'd0) begin
      n_fail++;
      $display("FAIL reset_a: stim=%h addr=%h busy=%b done=%b pass=%b err=%0d mask=%b vld=%b idx=%h, required all 0",
               stim_a, addr_a, busy_a, done_a, pass_a, err_a, mask_a, vld_a, idx_a);
    end
    n_tests++;
    if ({stim_b, busy_b, done_b, pass_b, err_b, mask_b, vld_b} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_b: stim=%h busy=%b done=%b err=%0d, required 0", stim_b, busy_b, done_b, err_b);
    end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_pass();
    int cyc;
    flt0 = '0; flt1 = '0;
    run_sweep(cyc);
    n_tests++;
    if (cyc - 1 !== 1536) begin n_fail++; $display("FAIL pass_latency: got %0d cycles, required 1536", cyc - 1); end
    n_tests++;
    if ({pass_a, busy_a, err_a, mask_a, vld_a} !== {1'b1, 1'b0, 10'd0, 2'b00, 1'b0}) begin
      n_fail++;
      $display("FAIL pass_result: pass=%b busy=%b err=%0d mask=%b vld=%b, required 1 0 0 00 0", pass_a, busy_a, err_a, mask_a, vld_a);
    end
    n_tests++;
    if (stim_a !== 9'h1FF || addr_a !== 9'h1FF) begin
      n_fail++;
      $display("FAIL pass_last_stim: stim=%h addr=%h, required 1ff 1ff", stim_a, addr_a);
    end
  endtask

  task automatic test_single_fault();
    int cyc;
    flt0 = '0; flt1 = '0; flt1[9'h1A5] = 1'b1;
    run_sweep(cyc);
    n_tests++;
    if ({err_a, mask_a, vld_a, idx_a, pass_a} !== {10'd1, 2'b10, 1'b1, 9'h1A5, 1'b0}) begin
      n_fail++;
      $display("FAIL single_fault: err=%0d mask=%b vld=%b idx=%h pass=%b, required 1 10 1 1a5 0", err_a, mask_a, vld_a, idx_a, pass_a);
    end
  endtask

  task automatic test_multi_channel();
    int cyc;
    flt0 = '0; flt1 = '0;
    flt0[9'h010] = 1'b1; flt1[9'h010] = 1'b1; flt0[9'h1FF] = 1'b1; flt1[9'h1FF] = 1'b1;
    run_sweep(cyc);
    n_tests++;
    if ({err_a, mask_a, idx_a} !== {10'd2, 2'b11, 9'h010}) begin
      n_fail++;
      $display("FAIL multi_channel: err=%0d mask=%b idx=%h, required 2 11 010", err_a, mask_a, idx_a);
    end
    n_tests++;
    if (stim_a !== 9'h1FF || cyc - 1 !== 1536) begin
      n_fail++;
      $display("FAIL multi_last: stim=%h cycles=%0d, required 1ff 1536", stim_a, cyc - 1);
    end
  endtask

  task automatic test_stop_on_err();
    int cyc;
    flt0 = '0; flt1 = '0; flt0[9'h020] = 1'b1; flt0[9'h030] = 1'b1;
    stop_on_err = 1'b1;
    run_sweep(cyc);
    n_tests++;
    if ({stim_a, err_a, busy_a, done_a, mask_a} !== {9'h020, 10'd1, 1'b0, 1'b1, 2'b01}) begin
      n_fail++;
      $display("FAIL stop_on_err: stim=%h err=%0d busy=%b done=%b mask=%b, required 020 1 0 1 01", stim_a, err_a, busy_a, done_a, mask_a);
    end
    n_tests++;
    if (cyc - 1 !== 99) begin n_fail++; $display("FAIL stop_latency: got %0d cycles, required 99", cyc - 1); end
    stop_on_err = 1'b0;
  endtask

  task automatic test_abort();
    int cyc;
    flt0 = '0; flt1 = '0; flt0[9'h050] = 1'b1;
    pulse_start();
    wait_stim(9'h080);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    n_tests++;
    if ({busy_a, done_a, pass_a} !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_idle: busy=%b done=%b pass=%b, required 000", busy_a, done_a, pass_a);
    end
    n_tests++;
    if ({err_a, vld_a, idx_a} !== {10'd1, 1'b1, 9'h050}) begin
      n_fail++;
      $display("FAIL abort_held: err=%0d vld=%b idx=%h, required 1 1 050", err_a, vld_a, idx_a);
    end
    @(negedge clk) begin start = 1'b1; abort = 1'b1; end
    @(negedge clk) begin start = 1'b0; abort = 1'b0; end
    n_tests++;
    if (busy_a !== 1'b0) begin n_fail++; $display("FAIL abort_over_start: busy=%b, required 0", busy_a); end
    pulse_start();
    n_tests++;
    if ({stim_a, err_a, mask_a, vld_a, busy_a, done_a} !== {9'h000, 10'd0, 2'b00, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL restart_clear: stim=%h err=%0d mask=%b vld=%b busy=%b done=%b, required 000 0 00 0 1 0",
               stim_a, err_a, mask_a, vld_a, busy_a, done_a);
    end
    wait_stim(9'h030);
    pulse_start();
    n_tests++;
    if (stim_a !== 9'h030 || busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL start_while_busy: stim=%h busy=%b, required 030 1", stim_a, busy_a);
    end
    wait_done(2000, cyc);
  endtask

  task automatic test_async_reset();
    flt0 = '0; flt1 = '0; flt0[9'h010] = 1'b1;
    pulse_start();
    wait_stim(9'h100);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({stim_a, addr_a, busy_a, done_a, pass_a, err_a, mask_a, vld_a, idx_a} !== 46'd0) begin
      n_fail++;
      $display("FAIL async_reset: stim=%h addr=%h busy=%b done=%b err=%0d mask=%b vld=%b idx=%h, required all 0",
               stim_a, addr_a, busy_a, done_a, err_a, mask_a, vld_a, idx_a);
    end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({busy_a, done_a, stim_a} !== 11'd0) begin
      n_fail++;
      $display("FAIL post_reset_idle: busy=%b done=%b stim=%h, required 0 0 000", busy_a, done_a, stim_a);
    end
  endtask

  task automatic test_saturation();
    int cyc;
    flt0 = '0; flt1 = '0;
    for (int i = 1; i <= 5; i++) flt0[i] = 1'b1;
    run_sweep(cyc);
    n_tests++;
    if (err_a !== 10'd5) begin n_fail++; $display("FAIL count_five: err=%0d, required 5", err_a); end
    n_tests++;
    if ({err_b, mask_b, idx_b, pass_b, done_b} !== {2'd3, 2'b01, 9'h001, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL saturate: err=%0d mask=%b idx=%h pass=%b done=%b, required 3 01 001 0 1", err_b, mask_b, idx_b, pass_b, done_b);
    end
  endtask

  initial begin
    test_reset();
    test_full_pass();
    test_single_fault();
    test_multi_channel();
    test_stop_on_err();
    test_abort();
    test_async_reset();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
